// File: rtl/decode_stage_param.sv
// ---------------------------------------------------------------------------
// decode_stage_param
//
// Purpose:
//   Pipeline decode stage. It contains a multi-port write-back register file
//   with write-to-read bypass and registers the decoded instruction fields for
//   the execute stage. The stage supports a hazard stall and a branch flush.
//   During a stall the held operands are refreshed from write-back traffic, so
//   an instruction that is waiting in decode picks up results that retire
//   while it waits.
//
// Parameters:
//   DATA_W   register / datapath width (>= 16)
//   NREG     register count (16 or 32); AW = log2(NREG)
//   PC_W     width of the PC+4 pass-through
//   NWR      number of write-back ports (1..4)
//   INIT_IDX 1: register i resets to i; 0: all registers reset to 0
//
// Ports:
//   clock, reset            rising-edge clock, async active-high reset
//   ip_instruction          32-bit instruction from fetch
//   ip_PC_plus_4            PC+4 from fetch (passed through)
//   ip_valid                fetch instruction valid
//   ip_stall                hazard-unit hold request
//   ip_flush                branch-taken squash request
//   ip_wr_en                per-port write enable              [NWR]
//   ip_wr_addr              per-port destination, port k at    [k*AW +: AW]
//   ip_wr_data              per-port write data, port k at     [k*DATA_W +: DATA_W]
//   op_valid                registered instruction valid
//   op_opcode               instr[31:26]
//   op_function_opcode      instr[5:0]
//   op_PC_plus_4            registered PC+4
//   op_read_data_1 / _2     rs / rt operands (bypassed)
//   op_immediate            sign-extended instr[15:0]
//   op_dec_rs / op_dec_rt   register indices from instr[25:21] / [20:16]
//   op_dest_reg_R_type      destination from instr[15:11]
//   op_dest_reg_I_type      destination from instr[20:16]
// ---------------------------------------------------------------------------
module decode_stage_param #(
  parameter int DATA_W   = 32,
  parameter int NREG     = 32,
  parameter int PC_W     = 10,
  parameter int NWR      = 2,
  parameter int INIT_IDX = 1,
  localparam int AW      = $clog2(NREG)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [31:0]           ip_instruction,
  input  logic [PC_W-1:0]       ip_PC_plus_4,
  input  logic                  ip_valid,
  input  logic                  ip_stall,
  input  logic                  ip_flush,
  input  logic [NWR-1:0]        ip_wr_en,
  input  logic [NWR*AW-1:0]     ip_wr_addr,
  input  logic [NWR*DATA_W-1:0] ip_wr_data,
  output logic                  op_valid,
  output logic [5:0]            op_opcode,
  output logic [5:0]            op_function_opcode,
  output logic [PC_W-1:0]       op_PC_plus_4,
  output logic [DATA_W-1:0]     op_read_data_1,
  output logic [DATA_W-1:0]     op_read_data_2,
  output logic [DATA_W-1:0]     op_immediate,
  output logic [AW-1:0]         op_dec_rs,
  output logic [AW-1:0]         op_dec_rt,
  output logic [AW-1:0]         op_dest_reg_R_type,
  output logic [AW-1:0]         op_dest_reg_I_type
);

  // Register file storage
  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];

  // Output pipeline registers
  logic              valid_q,  valid_d;
  logic [5:0]        opcode_q, opcode_d;
  logic [5:0]        funct_q,  funct_d;
  logic [PC_W-1:0]   pc_q,     pc_d;
  logic [DATA_W-1:0] rd1_q,    rd1_d;
  logic [DATA_W-1:0] rd2_q,    rd2_d;
  logic [DATA_W-1:0] imm_q,    imm_d;
  logic [AW-1:0]     rs_q,     rs_d;
  logic [AW-1:0]     rt_q,     rt_d;
  logic [AW-1:0]     dest_r_q, dest_r_d;
  logic [AW-1:0]     dest_i_q, dest_i_d;

  // Decoded fields of the incoming instruction
  logic [AW-1:0]     dec_rs;
  logic [AW-1:0]     dec_rt;
  logic [AW-1:0]     dec_rd;
  logic [DATA_W-1:0] dec_imm;

  // Operand values after bypass, plus stall-refresh values
  logic [DATA_W-1:0] byp_rs;
  logic [DATA_W-1:0] byp_rt;
  logic [DATA_W-1:0] refresh_rs;
  logic [DATA_W-1:0] refresh_rt;

  // Shift-amount bits and the upper index bits (NREG=16) are not used by this stage
  logic unused_instr_bits;
  assign unused_instr_bits = ^ip_instruction;

  // Register indices take the low AW bits of each 5-bit field
  assign dec_rs  = ip_instruction[21 +: AW];
  assign dec_rt  = ip_instruction[16 +: AW];
  assign dec_rd  = ip_instruction[11 +: AW];
  assign dec_imm = DATA_W'($signed(ip_instruction[15:0]));

  // Write-back ports are applied in ascending order, so the highest-index
  // port wins on a same-address collision. Address 0 is never written.
  always_comb begin
    logic [AW-1:0]     wa;
    logic [DATA_W-1:0] wd;
    wa     = '0;
    wd     = '0;
    regs_d = regs_q;
    for (int k = 0; k < NWR; k++) begin
      wa = ip_wr_addr[k*AW +: AW];
      wd = ip_wr_data[k*DATA_W +: DATA_W];
      if (ip_wr_en[k] && (wa != '0)) begin
        regs_d[wa] = wd;
      end
    end
  end

  // Operand bypass for the incoming instruction and stale-operand refresh for
  // the instruction held in the stage. In both cases a later port overrides
  // an earlier one. Index 0 always reads zero and is never bypassed.
  always_comb begin
    logic [AW-1:0]     wa;
    logic [DATA_W-1:0] wd;
    wa         = '0;
    wd         = '0;
    byp_rs     = (dec_rs == '0) ? '0 : regs_q[dec_rs];
    byp_rt     = (dec_rt == '0) ? '0 : regs_q[dec_rt];
    refresh_rs = rd1_q;
    refresh_rt = rd2_q;
    for (int k = 0; k < NWR; k++) begin
      wa = ip_wr_addr[k*AW +: AW];
      wd = ip_wr_data[k*DATA_W +: DATA_W];
      if (ip_wr_en[k] && (wa != '0)) begin
        if (wa == dec_rs) byp_rs     = wd;
        if (wa == dec_rt) byp_rt     = wd;
        if (wa == rs_q)   refresh_rs = wd;
        if (wa == rt_q)   refresh_rt = wd;
      end
    end
  end

  // Stage next-state: flush takes priority over stall. A flush still captures
  // the new instruction, but it kills the valid bit and both destinations so
  // that nothing downstream commits. A stall holds every field except the
  // operands, which track any write-back to the held rs/rt.
  always_comb begin
    valid_d  = valid_q;
    opcode_d = opcode_q;
    funct_d  = funct_q;
    pc_d     = pc_q;
    rd1_d    = rd1_q;
    rd2_d    = rd2_q;
    imm_d    = imm_q;
    rs_d     = rs_q;
    rt_d     = rt_q;
    dest_r_d = dest_r_q;
    dest_i_d = dest_i_q;
    if (ip_flush || !ip_stall) begin
      valid_d  = ip_valid;
      opcode_d = ip_instruction[31:26];
      funct_d  = ip_instruction[5:0];
      pc_d     = ip_PC_plus_4;
      rd1_d    = byp_rs;
      rd2_d    = byp_rt;
      imm_d    = dec_imm;
      rs_d     = dec_rs;
      rt_d     = dec_rt;
      dest_r_d = dec_rd;
      dest_i_d = dec_rt;
      if (ip_flush) begin
        valid_d  = 1'b0;
        dest_r_d = '0;
        dest_i_d = '0;
      end
    end else begin
      rd1_d = refresh_rs;
      rd2_d = refresh_rt;
    end
  end

  // The register file initialises asynchronously. Because reset holds this
  // block, writes presented during reset are dropped.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= (INIT_IDX != 0) ? DATA_W'(i) : '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Stage output registers clear asynchronously on reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q  <= 1'b0;
      opcode_q <= '0;
      funct_q  <= '0;
      pc_q     <= '0;
      rd1_q    <= '0;
      rd2_q    <= '0;
      imm_q    <= '0;
      rs_q     <= '0;
      rt_q     <= '0;
      dest_r_q <= '0;
      dest_i_q <= '0;
    end else begin
      valid_q  <= valid_d;
      opcode_q <= opcode_d;
      funct_q  <= funct_d;
      pc_q     <= pc_d;
      rd1_q    <= rd1_d;
      rd2_q    <= rd2_d;
      imm_q    <= imm_d;
      rs_q     <= rs_d;
      rt_q     <= rt_d;
      dest_r_q <= dest_r_d;
      dest_i_q <= dest_i_d;
    end
  end

  assign op_valid           = valid_q;
  assign op_opcode          = opcode_q;
  assign op_function_opcode = funct_q;
  assign op_PC_plus_4       = pc_q;
  assign op_read_data_1     = rd1_q;
  assign op_read_data_2     = rd2_q;
  assign op_immediate       = imm_q;
  assign op_dec_rs          = rs_q;
  assign op_dec_rt          = rt_q;
  assign op_dest_reg_R_type = dest_r_q;
  assign op_dest_reg_I_type = dest_i_q;

endmodule

// File: tb/tb_decode_stage_param.sv
// ---------------------------------------------------------------------------
// tb_decode_stage_param
//
// Self-checking bench for decode_stage_param with default parameters
// (DATA_W=32, NREG=32, PC_W=10, NWR=2, INIT_IDX=1). It applies a table of
// normal-capture vectors, followed by hand-written stall, flush and reset
// sequences.
// ---------------------------------------------------------------------------
module tb_decode_stage_param;

  localparam int DATA_W = 32;
  localparam int NREG   = 32;
  localparam int PC_W   = 10;
  localparam int NWR    = 2;
  localparam int AW     = 5;

  logic                  clock;
  logic                  reset;
  logic [31:0]           ip_instruction;
  logic [PC_W-1:0]       ip_PC_plus_4;
  logic                  ip_valid;
  logic                  ip_stall;
  logic                  ip_flush;
  logic [NWR-1:0]        ip_wr_en;
  logic [NWR*AW-1:0]     ip_wr_addr;
  logic [NWR*DATA_W-1:0] ip_wr_data;
  logic                  op_valid;
  logic [5:0]            op_opcode;
  logic [5:0]            op_function_opcode;
  logic [PC_W-1:0]       op_PC_plus_4;
  logic [DATA_W-1:0]     op_read_data_1;
  logic [DATA_W-1:0]     op_read_data_2;
  logic [DATA_W-1:0]     op_immediate;
  logic [AW-1:0]         op_dec_rs;
  logic [AW-1:0]         op_dec_rt;
  logic [AW-1:0]         op_dest_reg_R_type;
  logic [AW-1:0]         op_dest_reg_I_type;

  int errors = 0;
  int checks = 0;

  decode_stage_param #(
    .DATA_W(DATA_W), .NREG(NREG), .PC_W(PC_W), .NWR(NWR), .INIT_IDX(1)
  ) dut (
    .clock(clock),
    .reset(reset),
    .ip_instruction(ip_instruction),
    .ip_PC_plus_4(ip_PC_plus_4),
    .ip_valid(ip_valid),
    .ip_stall(ip_stall),
    .ip_flush(ip_flush),
    .ip_wr_en(ip_wr_en),
    .ip_wr_addr(ip_wr_addr),
    .ip_wr_data(ip_wr_data),
    .op_valid(op_valid),
    .op_opcode(op_opcode),
    .op_function_opcode(op_function_opcode),
    .op_PC_plus_4(op_PC_plus_4),
    .op_read_data_1(op_read_data_1),
    .op_read_data_2(op_read_data_2),
    .op_immediate(op_immediate),
    .op_dec_rs(op_dec_rs),
    .op_dec_rt(op_dec_rt),
    .op_dest_reg_R_type(op_dest_reg_R_type),
    .op_dest_reg_I_type(op_dest_reg_I_type)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] instr;
    logic [9:0]  pc;
    logic        valid;
    logic [1:0]  wr_en;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic [31:0] e_rd1;
    logic [31:0] e_rd2;
    logic        e_valid;
    logic [31:0] e_imm;
  } vec_t;

  vec_t vecs [8];

  function automatic logic [31:0] mkInstr(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // Drive every input for the coming edge
  task automatic applyStimulus(input logic [31:0] instr, input logic [9:0] pc,
                               input logic valid, input logic stall, input logic flush,
                               input logic [1:0] wr_en, input logic [4:0] wa0,
                               input logic [31:0] wd0, input logic [4:0] wa1,
                               input logic [31:0] wd1);
    ip_instruction = instr;
    ip_PC_plus_4   = pc;
    ip_valid       = valid;
    ip_stall       = stall;
    ip_flush       = flush;
    ip_wr_en       = wr_en;
    ip_wr_addr     = {wa1, wa0};
    ip_wr_data     = {wd1, wd0};
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one active edge and settle away from it
  task automatic stepEdge();
    @(posedge clock);
    #1;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " valid"},  32'(op_valid), 32'h0);
    checkOutput({tag, " opcode"}, 32'(op_opcode), 32'h0);
    checkOutput({tag, " funct"},  32'(op_function_opcode), 32'h0);
    checkOutput({tag, " pc"},     32'(op_PC_plus_4), 32'h0);
    checkOutput({tag, " rd1"},    op_read_data_1, 32'h0);
    checkOutput({tag, " rd2"},    op_read_data_2, 32'h0);
    checkOutput({tag, " imm"},    op_immediate, 32'h0);
    checkOutput({tag, " rs"},     32'(op_dec_rs), 32'h0);
    checkOutput({tag, " rt"},     32'(op_dec_rt), 32'h0);
    checkOutput({tag, " destR"},  32'(op_dest_reg_R_type), 32'h0);
    checkOutput({tag, " destI"},  32'(op_dest_reg_I_type), 32'h0);
  endtask

  initial begin
    logic [31:0] held;

    // Registers start at their index value; each entry below is computed
    // from that state plus the writes made by the earlier entries.
    vecs[0] = '{mkInstr(6'h23, 5'd5, 5'd7, 16'h0000), 10'h004, 1'b1, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0,
                32'h5, 32'h7, 1'b1, 32'h0};
    vecs[1] = '{mkInstr(6'h00, 5'd5, 5'd6, 16'h0000), 10'h008, 1'b1, 2'b11, 5'd5, 32'hAAAA, 5'd5, 32'hBBBB,
                32'hBBBB, 32'h6, 1'b1, 32'h0};
    vecs[2] = '{mkInstr(6'h08, 5'd5, 5'd3, 16'h1234), 10'h00C, 1'b1, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0,
                32'hBBBB, 32'h3, 1'b1, 32'h00001234};
    vecs[3] = '{mkInstr(6'h00, 5'd0, 5'd0, 16'h0000), 10'h010, 1'b0, 2'b01, 5'd0, 32'hFFFF, 5'd0, 32'h0,
                32'h0, 32'h0, 1'b0, 32'h0};
    vecs[4] = '{mkInstr(6'h0D, 5'd0, 5'd9, 16'h8001), 10'h014, 1'b1, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0,
                32'h0, 32'h9, 1'b1, 32'hFFFF8001};
    vecs[5] = '{mkInstr(6'h00, 5'd9, 5'd10, 16'h5022), 10'h018, 1'b1, 2'b11, 5'd9, 32'h11, 5'd10, 32'h22,
                32'h11, 32'h22, 1'b1, 32'h00005022};
    vecs[6] = '{mkInstr(6'h00, 5'd10, 5'd9, 16'h0000), 10'h01C, 1'b1, 2'b10, 5'd0, 32'h0, 5'd0, 32'h55,
                32'h22, 32'h11, 1'b1, 32'h0};
    vecs[7] = '{mkInstr(6'h04, 5'd12, 5'd12, 16'hFFFE), 10'h020, 1'b1, 2'b01, 5'd12, 32'h77, 5'd12, 32'h99,
                32'h77, 32'h77, 1'b1, 32'hFFFFFFFE};

    // Reset from time zero: outputs must clear before any clock edge
    reset = 1'b0;
    applyStimulus(32'h0, 10'h0, 1'b0, 1'b0, 1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    #2;
    reset = 1'b1;
    #1;
    checkAllZero("reset");
    stepEdge();
    reset = 1'b0;

    $display("[TB] normal-capture vectors");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].instr, vecs[i].pc, vecs[i].valid, 1'b0, 1'b0, vecs[i].wr_en,
                    vecs[i].wa0, vecs[i].wd0, vecs[i].wa1, vecs[i].wd1);
      stepEdge();
      checkOutput($sformatf("v%0d rd1", i), op_read_data_1, vecs[i].e_rd1);
      checkOutput($sformatf("v%0d rd2", i), op_read_data_2, vecs[i].e_rd2);
      checkOutput($sformatf("v%0d valid", i), 32'(op_valid), 32'(vecs[i].e_valid));
      checkOutput($sformatf("v%0d imm", i), op_immediate, vecs[i].e_imm);
      checkOutput($sformatf("v%0d opcode", i), 32'(op_opcode), 32'(vecs[i].instr[31:26]));
      checkOutput($sformatf("v%0d funct", i), 32'(op_function_opcode), 32'(vecs[i].instr[5:0]));
      checkOutput($sformatf("v%0d pc", i), 32'(op_PC_plus_4), 32'(vecs[i].pc));
      checkOutput($sformatf("v%0d rs", i), 32'(op_dec_rs), 32'(vecs[i].instr[25:21]));
      checkOutput($sformatf("v%0d rt", i), 32'(op_dec_rt), 32'(vecs[i].instr[20:16]));
      checkOutput($sformatf("v%0d destR", i), 32'(op_dest_reg_R_type), 32'(vecs[i].instr[15:11]));
      checkOutput($sformatf("v%0d destI", i), 32'(op_dest_reg_I_type), 32'(vecs[i].instr[20:16]));
    end

    $display("[TB] stall with operand refresh");
    // Capture rs=12 (0x77), rt=7 (still its reset value 7)
    applyStimulus(mkInstr(6'h2B, 5'd12, 5'd7, 16'h0ABC), 10'h040, 1'b1, 1'b0, 1'b0,
                  2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    stepEdge();
    checkOutput("pre-stall rd2", op_read_data_2, 32'h7);
    for (int c = 0; c < 3; c++) begin
      if (c == 1)
        applyStimulus(32'hFFFF_FFFF, 10'h3FF, 1'b0, 1'b1, 1'b0, 2'b01, 5'd7, 32'h1234, 5'd0, 32'h0);
      else
        applyStimulus(32'hFFFF_FFFF, 10'h3FF, 1'b0, 1'b1, 1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
      stepEdge();
      checkOutput($sformatf("stall%0d rd2", c), op_read_data_2, (c == 0) ? 32'h7 : 32'h1234);
      checkOutput($sformatf("stall%0d rd1", c), op_read_data_1, 32'h77);
      checkOutput($sformatf("stall%0d opcode", c), 32'(op_opcode), 32'h2B);
      checkOutput($sformatf("stall%0d valid", c), 32'(op_valid), 32'h1);
      checkOutput($sformatf("stall%0d pc", c), 32'(op_PC_plus_4), 32'h040);
      checkOutput($sformatf("stall%0d imm", c), op_immediate, 32'h0ABC);
      checkOutput($sformatf("stall%0d destI", c), 32'(op_dest_reg_I_type), 32'h7);
      checkOutput($sformatf("stall%0d destR", c), 32'(op_dest_reg_R_type), 32'h1);
    end
    // The array itself was written during the stall
    applyStimulus(mkInstr(6'h00, 5'd7, 5'd0, 16'h0000), 10'h044, 1'b1, 1'b0, 1'b0,
                  2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    stepEdge();
    checkOutput("r7 after stall", op_read_data_1, 32'h1234);

    $display("[TB] flush together with stall");
    applyStimulus(mkInstr(6'h00, 5'd1, 5'd2, 16'h4820), 10'h048, 1'b1, 1'b1, 1'b1,
                  2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    stepEdge();
    checkOutput("flush valid", 32'(op_valid), 32'h0);
    checkOutput("flush destR", 32'(op_dest_reg_R_type), 32'h0);
    checkOutput("flush destI", 32'(op_dest_reg_I_type), 32'h0);
    checkOutput("flush rd1", op_read_data_1, 32'h1);
    checkOutput("flush rd2", op_read_data_2, 32'h2);
    checkOutput("flush funct", 32'(op_function_opcode), 32'h20);
    checkOutput("flush imm", op_immediate, 32'h4820);
    checkOutput("flush pc", 32'(op_PC_plus_4), 32'h048);

    $display("[TB] reset between edges");
    applyStimulus(mkInstr(6'h3F, 5'd12, 5'd9, 16'h7FFF), 10'h050, 1'b1, 1'b0, 1'b0,
                  2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    stepEdge();
    checkOutput("pre-reset valid", 32'(op_valid), 32'h1);
    // Mid-stall reset while a write to r12 is presented
    applyStimulus(mkInstr(6'h01, 5'd12, 5'd9, 16'h8001), 10'h054, 1'b1, 1'b1, 1'b1,
                  2'b01, 5'd12, 32'hDEAD, 5'd0, 32'h0);
    #2;
    reset = 1'b1;
    #1;
    checkAllZero("async reset");
    stepEdge();
    checkAllZero("held reset");
    held = 32'h0;
    applyStimulus(mkInstr(6'h01, 5'd12, 5'd9, 16'h8001), 10'h054, 1'b1, 1'b0, 1'b0,
                  2'b00, 5'd0, 32'h0, 5'd0, held);
    reset = 1'b0;
    stepEdge();
    checkOutput("post-reset imm", op_immediate, 32'hFFFF8001);
    checkOutput("post-reset valid", 32'(op_valid), 32'h1);
    checkOutput("post-reset rd1", op_read_data_1, 32'hC);
    checkOutput("post-reset rd2", op_read_data_2, 32'h9);
    checkOutput("post-reset opcode", 32'(op_opcode), 32'h01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
